// File: rtl/queue_bank.sv
// queue_bank: bank of NUM_REQS circular FIFOs, one per arbiter requestor.
// Pushes are steered into a queue by in_id; the arbiter sees one request bit
// per non-empty queue and pops with a one-hot grant. The popped packet shows
// up one cycle after the grant.
//
// Ports:
//   clk       single clock, rising edge
//   rst       synchronous active-low reset
//   in_valid  push request
//   in_id     target queue of the push
//   in_data   push payload
//   in_rdy    push accepted when in_valid & in_rdy
//   reqs      bit i set while queue i holds at least one entry
//   gnt       one-hot pop request from the arbiter
//   out_valid one-cycle pulse, popped packet valid
//   out_id    queue the popped packet came from (held when idle)
//   out_data  popped payload (held when idle)
//   err       sticky: grant to an empty queue or non-one-hot grant
//   drop_cnt  saturating count of discarded pushes
//
// Compile-time option QUEUE_BANK_DROP_EN: in_rdy is tied high and pushes to a
// full queue are discarded and counted in drop_cnt. Without it, in_rdy
// back-pressures on a full target queue and drop_cnt stays 0.
module queue_bank #(
   parameter int NUM_REQS = 4,
   parameter int DWID     = 8,
   parameter int DEPTH    = 4,
   parameter int CNTWID   = $clog2(NUM_REQS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic [CNTWID-1:0]   in_id,
   input  logic [DWID-1:0]     in_data,
   output logic                in_rdy,
   output logic [NUM_REQS-1:0] reqs,
   input  logic [NUM_REQS-1:0] gnt,
   output logic                out_valid,
   output logic [CNTWID-1:0]   out_id,
   output logic [DWID-1:0]     out_data,
   output logic                err,
   output logic [7:0]          drop_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DWID-1:0]     mem   [NUM_REQS][DEPTH];
   logic [PW-1:0]       head  [NUM_REQS];
   logic [PW-1:0]       tail  [NUM_REQS];
   logic [CW-1:0]       count [NUM_REQS];

   logic                full_sel;
   logic                push_do;
   logic                pop_ok;
   logic                gnt_bad;
   logic [CNTWID-1:0]   pop_id;
   logic [NUM_REQS-1:0] push_vec;
   logic [NUM_REQS-1:0] pop_vec;

   // reqs depends only on registered counts, never on gnt or in_valid.
   always_comb begin
      reqs = '0;
      for (int i = 0; i < NUM_REQS; i++)
         reqs[i] = (count[i] != '0);
   end

   // Fullness of the addressed queue; an id with no queue behind it reads as
   // full so it can never be written.
   always_comb begin
      full_sel = 1'b1;
      for (int i = 0; i < NUM_REQS; i++)
         if (in_id == CNTWID'(i))
            full_sel = (count[i] == CW'(DEPTH));
   end

`ifdef QUEUE_BANK_DROP_EN
   assign in_rdy = 1'b1;
`else
   assign in_rdy = ~full_sel;
`endif

   // Full is judged on the current count, so a same-cycle pop never makes
   // room for a push into a full queue.
   assign push_do = in_valid & ~full_sel;
   assign pop_ok  = $onehot(gnt) && ((gnt & reqs) != '0);
   assign gnt_bad = (gnt != '0) && !pop_ok;

   always_comb begin
      pop_id   = '0;
      push_vec = '0;
      pop_vec  = pop_ok ? gnt : '0;
      for (int i = 0; i < NUM_REQS; i++) begin
         if (gnt[i])
            pop_id = CNTWID'(i);
         push_vec[i] = push_do && (in_id == CNTWID'(i));
      end
   end

   // Payload storage carries no reset; pointers decide what is live.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REQS; i++)
         if (rst && push_vec[i])
            mem[i][tail[i]] <= in_data;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REQS; i++) begin
            head[i]  <= '0;
            tail[i]  <= '0;
            count[i] <= '0;
         end
         out_valid <= 1'b0;
         out_id    <= '0;
         out_data  <= '0;
         err       <= 1'b0;
      end else begin
         out_valid <= pop_ok;
         if (pop_ok) begin
            out_id   <= pop_id;
            out_data <= mem[pop_id][head[pop_id]];
         end
         if (gnt_bad)
            err <= 1'b1;
         for (int i = 0; i < NUM_REQS; i++) begin
            if (push_vec[i])
               tail[i] <= tail[i] + PW'(1);
            if (pop_vec[i])
               head[i] <= head[i] + PW'(1);
            count[i] <= count[i] + CW'(push_vec[i]) - CW'(pop_vec[i]);
         end
      end
   end

`ifdef QUEUE_BANK_DROP_EN
   always_ff @(posedge clk) begin
      if (!rst)
         drop_cnt <= '0;
      else if (in_valid && full_sel && (drop_cnt != 8'hFF))
         drop_cnt <= drop_cnt + 8'd1;
   end
`else
   assign drop_cnt = '0;
`endif

endmodule
